// File: rtl/nanci_pkg.sv
// rtl/nanci_pkg.sv - shared types and helpers for the Nanci row drain
package nanci_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A PE word is {addr, data}
    function automatic int word_width(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    // The sort key is the data field, i.e. the low data_width bits of a word
    function automatic logic [31:0] key_of(input logic [31:0] word, input int data_width);
        return word & ((32'd1 << data_width) - 32'd1);
    endfunction

endpackage

// File: rtl/nanci_row_drain_if.sv
// rtl/nanci_row_drain_if.sv - snapshot input, stream output and status of one row drain
interface nanci_row_drain_if #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3
);
    import nanci_pkg::*;

    localparam int W  = word_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic            i_done;
    logic [N*W-1:0]  i_row;
    logic            i_ready;
    logic            o_valid;
    logic [W-1:0]    o_data;
    logic [IW-1:0]   o_index;
    logic            o_last;
    logic            o_busy;
    logic            o_order_err;
    logic            o_overrun;
    logic [7:0]      o_frame_cnt;

    // Drain side: takes the row snapshot, drives the word stream
    modport master (
        input  i_done, i_row, i_ready,
        output o_valid, o_data, o_index, o_last, o_busy,
        output o_order_err, o_overrun, o_frame_cnt
    );

    // Mesh/host side
    modport slave (
        output i_done, i_row, i_ready,
        input  o_valid, o_data, o_index, o_last, o_busy,
        input  o_order_err, o_overrun, o_frame_cnt
    );

endinterface

// File: rtl/nanci_row_drain.sv
// rtl/nanci_row_drain.sv - snapshots a PE row on sort completion and streams it out with order checking
module nanci_row_drain
    import nanci_pkg::*;
#(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter int REVERSE    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    nanci_row_drain_if.master    bus
);

    localparam int W  = word_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_P    = IW'(N - 1);
    localparam logic [IW-1:0] FIRST_IDX = (REVERSE != 0) ? IW'(N - 1) : '0;

    state_t                  state;
    state_t                  state_next;
    logic [N*W-1:0]          row_buf;
    logic [IW-1:0]           pos;
    logic [DATA_WIDTH-1:0]   prev_key;
    logic [DATA_WIDTH-1:0]   cur_key;
    logic [IW-1:0]           next_pos;
    logic [IW-1:0]           next_idx;
    logic                    xfer;
    logic                    final_xfer;
    logic                    accept;

    // Odd snake rows read the row from the far end
    function automatic logic [IW-1:0] emit_idx(input logic [IW-1:0] p);
        return (REVERSE != 0) ? LAST_P - p : p;
    endfunction

    assign bus.o_valid = (state == SEND);
    assign bus.o_busy  = (state == SEND);

    assign xfer       = bus.o_valid & bus.i_ready;
    assign final_xfer = xfer && (pos == LAST_P);
    assign accept     = (state == IDLE) && bus.i_done;
    assign next_pos   = pos + 1'b1;
    assign next_idx   = emit_idx(next_pos);
    assign cur_key    = DATA_WIDTH'(key_of(32'(bus.o_data), DATA_WIDTH));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: arm on i_done when idle, return to idle after the last word is taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_done) state_next = SEND;
            SEND:    if (final_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot buffer, output word registers, order check and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_buf         <= '0;
            pos             <= '0;
            prev_key        <= '0;
            bus.o_data      <= '0;
            bus.o_index     <= '0;
            bus.o_last      <= 1'b0;
            bus.o_order_err <= 1'b0;
            bus.o_overrun   <= 1'b0;
            bus.o_frame_cnt <= '0;
        end else begin
            if (accept) begin
                row_buf     <= bus.i_row;
                pos         <= '0;
                bus.o_data  <= bus.i_row[int'(FIRST_IDX)*W +: W];
                bus.o_index <= FIRST_IDX;
                bus.o_last  <= 1'b0;
            end else if (xfer) begin
                prev_key <= cur_key;
                if ((pos != '0) && (cur_key < prev_key)) begin
                    bus.o_order_err <= 1'b1;
                end
                if (final_xfer) begin
                    bus.o_frame_cnt <= bus.o_frame_cnt + 8'd1;
                end else begin
                    pos         <= next_pos;
                    bus.o_data  <= row_buf[int'(next_idx)*W +: W];
                    bus.o_index <= next_idx;
                    bus.o_last  <= (next_pos == LAST_P);
                end
            end
            // A snapshot offered while a drain is in progress is dropped
            if ((state == SEND) && bus.i_done) begin
                bus.o_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nanci_row_drain.sv
// tb/tb_nanci_row_drain.sv - scoreboard bench for nanci_row_drain, forward and reversed rows
module tb_nanci_row_drain;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 3;
    localparam int W  = AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nanci_row_drain_if #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    nanci_row_drain_if #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    nanci_row_drain #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REVERSE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    nanci_row_drain #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REVERSE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   idx;
        logic         last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: state after the next clock edge
    logic         m_busy  [2];
    int           m_pos   [2];
    logic [W-1:0] m_seq   [2][N];
    logic         m_oerr  [2];
    logic         m_ovr   [2];
    logic [7:0]   m_frame [2];

    // Expected status for the cycle currently visible on the outputs
    logic         e_valid [2];
    logic         e_oerr  [2];
    logic         e_ovr   [2];
    logic [7:0]   e_frame [2];

    localparam logic [N*W-1:0] ROW_A = {6'b011101, 6'b010011, 6'b001010, 6'b000001};
    localparam logic [N*W-1:0] ROW_C = {6'b000101, 6'b000101, 6'b000101, 6'b000101};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_pos[k]   = 0;
            m_oerr[k]  = 1'b0;
            m_ovr[k]   = 1'b0;
            m_frame[k] = 8'd0;
            e_valid[k] = 1'b0;
            e_oerr[k]  = 1'b0;
            e_ovr[k]   = 1'b0;
            e_frame[k] = 8'd0;
            for (int j = 0; j < N; j++) m_seq[k][j] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic drive(input logic d, input logic [N*W-1:0] row, input logic r);
        bus0.i_done = d;  bus1.i_done = d;
        bus0.i_row  = row; bus1.i_row = row;
        bus0.i_ready = r; bus1.i_ready = r;
    endtask

    // One clock of stimulus: publish current expectations, drive inputs, advance the model
    task automatic step(input logic d, input logic [N*W-1:0] row, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = m_busy[k];
            e_oerr[k]  = m_oerr[k];
            e_ovr[k]   = m_ovr[k];
            e_frame[k] = m_frame[k];
        end
        drive(d, row, r);
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k]) begin
                if (d) m_ovr[k] = 1'b1;
                if (r) begin
                    if (m_pos[k] > 0 &&
                        m_seq[k][m_pos[k]][DW-1:0] < m_seq[k][m_pos[k]-1][DW-1:0])
                        m_oerr[k] = 1'b1;
                    m_pos[k]++;
                    if (m_pos[k] == N) begin
                        m_busy[k]  = 1'b0;
                        m_frame[k] = m_frame[k] + 8'd1;
                    end
                end
            end else if (d) begin
                for (int j = 0; j < N; j++) begin
                    int pe;
                    pe = (k == 1) ? N - 1 - j : j;
                    m_seq[k][j] = row[pe*W +: W];
                    e.data = row[pe*W +: W];
                    e.idx  = 2'(pe);
                    e.last = (j == N - 1);
                    if (k == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                m_busy[k] = 1'b1;
                m_pos[k]  = 0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy[0] || m_busy[1]) && n < 40) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " u0 valid"}, 32'(bus0.o_valid), 0);
        check({tag, " u0 data"},  32'(bus0.o_data), 0);
        check({tag, " u0 index"}, 32'(bus0.o_index), 0);
        check({tag, " u0 last"},  32'(bus0.o_last), 0);
        check({tag, " u0 busy"},  32'(bus0.o_busy), 0);
        check({tag, " u0 oerr"},  32'(bus0.o_order_err), 0);
        check({tag, " u0 ovr"},   32'(bus0.o_overrun), 0);
        check({tag, " u0 frame"}, 32'(bus0.o_frame_cnt), 0);
        check({tag, " u1 valid"}, 32'(bus1.o_valid), 0);
        check({tag, " u1 data"},  32'(bus1.o_data), 0);
        check({tag, " u1 index"}, 32'(bus1.o_index), 0);
        check({tag, " u1 frame"}, 32'(bus1.o_frame_cnt), 0);
    endtask

    task automatic mon(input int k, input logic v, input logic [W-1:0] d, input logic [1:0] ix,
                       input logic l, input logic b, input logic oe, input logic ov,
                       input logic [7:0] fc, input logic rdy);
        exp_t e;
        int   sz;
        check($sformatf("u%0d valid", k), 32'(v), 32'(e_valid[k]));
        check($sformatf("u%0d busy", k), 32'(b), 32'(e_valid[k]));
        check($sformatf("u%0d order_err", k), 32'(oe), 32'(e_oerr[k]));
        check($sformatf("u%0d overrun", k), 32'(ov), 32'(e_ovr[k]));
        check($sformatf("u%0d frame_cnt", k), 32'(fc), 32'(e_frame[k]));
        if (v) begin
            sz = (k == 0) ? q0.size() : q1.size();
            vectors++;
            if (sz == 0) begin
                miscompares++;
                $display("FAIL u%0d unexpected word: got %0h, required none", k, d);
            end else begin
                e = (k == 0) ? q0[0] : q1[0];
                check($sformatf("u%0d data", k), 32'(d), 32'(e.data));
                check($sformatf("u%0d index", k), 32'(ix), 32'(e.idx));
                check($sformatf("u%0d last", k), 32'(l), 32'(e.last));
                if (rdy) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    // Monitor: compare visible outputs against the scoreboard mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.o_valid, bus0.o_data, bus0.o_index, bus0.o_last, bus0.o_busy,
                bus0.o_order_err, bus0.o_overrun, bus0.o_frame_cnt, bus0.i_ready);
            mon(1, bus1.o_valid, bus1.o_data, bus1.o_index, bus1.o_last, bus1.o_busy,
                bus1.o_order_err, bus1.o_overrun, bus1.o_frame_cnt, bus1.i_ready);
        end
    end

    initial begin
        logic [N*W-1:0] row_b;
        logic [0:6]     bp;
        int             nwrap;

        drive(1'b0, '0, 1'b0);
        model_reset();
        rst = 1'b1;
        #1;
        check_zero("reset");
        #22;
        rst = 1'b0;

        // Forward and reversed drain at full rate
        step(1'b1, ROW_A, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);
        check("dir u0 oerr", 32'(bus0.o_order_err), 0);
        check("dir u1 oerr", 32'(bus1.o_order_err), 1);
        check("dir u0 frame", 32'(bus0.o_frame_cnt), 1);

        // Backpressure pattern
        bp = 7'b0010111;
        step(1'b1, ROW_A, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, bp[i]);
        drain();

        // Overrun mid-drain and in the final-transfer cycle
        row_b = 24'($urandom);
        step(1'b1, ROW_A, 1'b0);
        step(1'b1, row_b, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, row_b, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();
        check("ovr u0", 32'(bus0.o_overrun), 1);

        // Asynchronous reset after two transfers, then an equal-key row
        step(1'b1, ROW_A, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        model_reset();
        drive(1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        step(1'b1, ROW_C, 1'b1);
        drain();
        step(1'b0, '0, 1'b0);
        check("eq u0 oerr", 32'(bus0.o_order_err), 0);
        check("eq u1 oerr", 32'(bus1.o_order_err), 0);

        // Random traffic
        repeat (400) step($urandom_range(0, 3) == 0, 24'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Run complete snapshots until the frame counter wraps back to zero
        nwrap = 256 - int'(m_frame[0]);
        repeat (nwrap) begin
            step(1'b1, 24'($urandom), 1'b1);
            repeat (4) step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("wrap u0 frame", 32'(bus0.o_frame_cnt), 0);
        check("wrap u1 frame", 32'(bus1.o_frame_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
